// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader. Consumes a byte stream made of a
// 16-bit big-endian word count followed by that many big-endian 32-bit
// instruction words. Each assembled word is written into instruction memory
// at consecutive word addresses starting from 0. Once the load completes, the
// loader releases the CPU by raising cpu_run. A header count larger than the
// memory depth is rejected: the loader raises error and performs no writes.
//
// Ports
//   clock       : single clock, rising edge
//   reset_n     : asynchronous active-low reset
//   byte_valid  : upstream offers byte_data this cycle
//   byte_data   : load stream byte
//   byte_ready  : loader accepts a byte this cycle (transfer = valid && ready)
//   restart     : begin a new load; only honoured in DONE or ERROR
//   imem_we     : instruction-memory write strobe (one cycle per word)
//   imem_addr   : instruction-memory word address
//   imem_wdata  : instruction word to write
//   cpu_run     : high releases the CPU to fetch
//   busy        : a load is in progress
//   error       : header word count exceeded memory depth
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Depth is held in 17 bits so that a full 16-bit count can be compared
    // against it even when ADDR_WIDTH is 16.
    localparam logic [16:0]           DEPTH     = 17'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic [7:0]              r_count_hi;
    logic [15:0]             r_remaining;
    logic [ADDR_WIDTH-1:0]   r_word_idx;
    logic [1:0]              r_byte_idx;
    logic [31:0]             r_word;

    logic                    r_byte_ready;
    logic                    r_imem_we;
    logic [ADDR_WIDTH-1:0]   r_imem_addr;
    logic [31:0]             r_imem_wdata;
    logic                    r_cpu_run;
    logic                    r_busy;
    logic                    r_error;

    logic                    w_xfer;
    logic [15:0]             w_count;
    logic                    w_count_too_big;
    logic [31:0]             w_word_next;

    assign w_xfer          = byte_valid && r_byte_ready;
    assign w_count         = {r_count_hi, byte_data};
    assign w_count_too_big = ({1'b0, w_count} > DEPTH);
    // First byte of a word ends up in bits 31:24 after four shifts.
    assign w_word_next     = {r_word[23:0], byte_data};

    assign byte_ready = r_byte_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_run    = r_cpu_run;
    assign busy       = r_busy;
    assign error      = r_error;

    // Loader FSM: state, datapath and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_count_hi   <= 8'd0;
            r_remaining  <= 16'd0;
            r_word_idx   <= ADDR_ZERO;
            r_byte_idx   <= 2'd0;
            r_word       <= 32'd0;
            r_byte_ready <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= ADDR_ZERO;
            r_imem_wdata <= 32'd0;
            r_cpu_run    <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state      <= ST_HDR_HI;
                    r_byte_ready <= 1'b1;
                    r_busy       <= 1'b1;
                end

                ST_HDR_HI: begin
                    if (w_xfer) begin
                        r_count_hi <= byte_data;
                        r_state    <= ST_HDR_LO;
                    end
                end

                ST_HDR_LO: begin
                    if (w_xfer) begin
                        if (w_count == 16'd0) begin
                            r_state      <= ST_DONE;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_cpu_run    <= 1'b1;
                        end else if (w_count_too_big) begin
                            r_state      <= ST_ERROR;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_error      <= 1'b1;
                        end else begin
                            r_state     <= ST_DATA;
                            r_remaining <= w_count;
                            r_word_idx  <= ADDR_ZERO;
                            r_byte_idx  <= 2'd0;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_xfer) begin
                        r_word     <= w_word_next;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            // Strobe is registered here so it is high for
                            // exactly the one cycle spent in WRITE.
                            r_state      <= ST_WRITE;
                            r_byte_ready <= 1'b0;
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_word_idx;
                            r_imem_wdata <= w_word_next;
                        end
                    end
                end

                ST_WRITE: begin
                    r_imem_we   <= 1'b0;
                    r_word_idx  <= r_word_idx + ADDR_ONE;
                    r_remaining <= r_remaining - 16'd1;
                    // Termination uses the remaining count rather than the
                    // index, so a full-depth load whose index wraps to 0
                    // still stops after the last word.
                    if (r_remaining == 16'd1) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_cpu_run <= 1'b1;
                    end else begin
                        r_state      <= ST_DATA;
                        r_byte_ready <= 1'b1;
                    end
                end

                ST_DONE, ST_ERROR: begin
                    if (restart) begin
                        r_state      <= ST_HDR_HI;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_cpu_run    <= 1'b0;
                        r_error      <= 1'b0;
                        r_word_idx   <= ADDR_ZERO;
                        r_byte_idx   <= 2'd0;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                    r_imem_we    <= 1'b0;
                    r_cpu_run    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_error      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Drives byte streams into imem_loader with random valid gaps and random
// (ignored) restart noise. A stream-level model counts accepted bytes and
// derives every expected output from the byte position in the stream; it is
// compared against the DUT on every falling edge. Directed literal checks pin
// the written words for the documented example streams.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          restart;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          busy;
    logic          error;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .error      (error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Writes observed on the DUT, {addr, data}
    logic [39:0] wlog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Inputs as seen by the DUT at each rising edge
    logic       s_rstn    = 1'b0;
    logic       s_valid   = 1'b0;
    logic [7:0] s_data    = 8'd0;
    logic       s_restart = 1'b0;

    // Capture what the DUT sampled at the rising edge.
    always @(posedge clock) begin
        s_rstn    <= reset_n;
        s_valid   <= byte_valid;
        s_data    <= byte_data;
        s_restart <= restart;
    end

    // Stream-level model: everything follows from how many bytes of the
    // current load have been accepted.
    bit          m_started, m_pend, m_done, m_err;
    int          m_bytes, m_cnt, m_writes;
    logic [31:0] m_word, m_data;
    int          m_addr;

    task automatic model_reset();
        m_started = 0; m_pend = 0; m_done = 0; m_err = 0;
        m_bytes = 0; m_cnt = 0; m_writes = 0;
        m_word = 32'd0; m_data = 32'd0; m_addr = 0;
    endtask

    task automatic model_edge();
        if (!m_started) begin
            m_started = 1;
        end else if (m_pend) begin
            m_pend = 0;
            m_writes++;
            if (m_writes == m_cnt) m_done = 1;
        end else if (m_done || m_err) begin
            if (s_restart) begin
                m_done = 0; m_err = 0; m_bytes = 0; m_writes = 0;
            end
        end else if (s_valid) begin
            m_bytes++;
            if (m_bytes == 1) begin
                m_cnt = int'(s_data) * 256;
            end else if (m_bytes == 2) begin
                m_cnt = m_cnt + int'(s_data);
                if (m_cnt == 0) m_done = 1;
                else if (m_cnt > DEPTH) m_err = 1;
            end else begin
                m_word = {m_word[23:0], s_data};
                if ((m_bytes - 2) % 4 == 0) begin
                    m_pend = 1;
                    m_addr = (m_bytes - 3) / 4;
                    m_data = m_word;
                end
            end
        end
    endtask

    // Compare process: advance the model and check every output each cycle.
    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (!reset_n || !s_rstn) model_reset();
            else model_edge();
            chk("byte_ready", 64'(byte_ready), 64'(m_started && !m_pend && !m_done && !m_err));
            chk("busy",       64'(busy),       64'(m_started && !m_done && !m_err));
            chk("imem_we",    64'(imem_we),    64'(m_pend));
            chk("imem_addr",  64'(imem_addr),  64'(m_addr));
            chk("imem_wdata", 64'(imem_wdata), 64'(m_data));
            chk("cpu_run",    64'(cpu_run),    64'(m_done));
            chk("error",      64'(error),      64'(m_err));
            if (imem_we === 1'b1) wlog.push_back({imem_addr, imem_wdata});
        end
    end

    // Offer each byte until accepted; p = percent of cycles with valid low.
    task automatic send_q(input logic [7:0] q[$], input int p);
        int   tries;
        bit   acc;
        logic rdy;
        for (int i = 0; i < q.size(); i++) begin
            tries = 0;
            acc   = 0;
            while (!acc) begin
                byte_valid = ($urandom_range(99) >= p);
                byte_data  = byte_valid ? q[i] : 8'($urandom);
                restart    = ($urandom_range(19) == 0);
                rdy        = byte_ready;
                @(posedge clock); #2;
                acc = byte_valid && rdy;
                tries++;
                if (tries > 500) begin
                    $display("FAIL send_timeout: byte %0d never accepted", i);
                    $fatal(1, "stalled");
                end
            end
        end
        byte_valid = 1'b0;
        restart    = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(cpu_run || error)) begin
            @(posedge clock); #2;
            n++;
            if (n > 3000) begin
                $display("FAIL wait_end_timeout: cpu_run=%0d error=%0d", cpu_run, error);
                $fatal(1, "stalled");
            end
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clock); #2;
        restart = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_ready",  64'(byte_ready), 64'd0);
        chk("rst_wdata",  64'(imem_wdata), 64'd0);
        chk("rst_cpurun", 64'(cpu_run),    64'd0);
        reset_n = 1'b1;
        chk("rel_ready0", 64'(byte_ready), 64'd0);
        @(posedge clock); #2;
        chk("rel_ready1", 64'(byte_ready), 64'd1);
    endtask

    logic [7:0]  q[$];
    logic [31:0] w;
    int          n;

    initial begin
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        restart    = 1'b0;
        @(posedge clock); #2;
        do_reset();

        // Two-word example, valid held high
        q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
        wlog.delete();
        send_q(q, 0);
        wait_end();
        chk("ex2_nwrites", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("ex2_w0", 64'(wlog[0]), 64'h00_2008_0005);
            chk("ex2_w1", 64'(wlog[1]), 64'h01_AC08_0004);
        end
        chk("ex2_cpurun", 64'(cpu_run), 64'd1);
        pulse_restart();

        // Same stream with heavy valid gaps
        wlog.delete();
        send_q(q, 50);
        wait_end();
        chk("gap_nwrites", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("gap_w0", 64'(wlog[0]), 64'h00_2008_0005);
            chk("gap_w1", 64'(wlog[1]), 64'h01_AC08_0004);
        end
        pulse_restart();

        // Zero-length load
        wlog.delete();
        q = '{8'h00, 8'h00};
        send_q(q, 0);
        wait_end();
        chk("zero_nwrites", 64'(wlog.size()), 64'd0);
        chk("zero_cpurun",  64'(cpu_run),     64'd1);
        chk("zero_busy",    64'(busy),        64'd0);
        pulse_restart();

        // Oversized count: 257 words
        wlog.delete();
        q = '{8'h01, 8'h01};
        send_q(q, 0);
        wait_end();
        chk("big_error",   64'(error),       64'd1);
        chk("big_ready",   64'(byte_ready),  64'd0);
        chk("big_nwrites", 64'(wlog.size()), 64'd0);
        pulse_restart();
        chk("big_rst_error", 64'(error),      64'd0);
        chk("big_rst_ready", 64'(byte_ready), 64'd1);

        // Full depth: 256 words
        wlog.delete();
        q = '{8'h01, 8'h00};
        for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
        send_q(q, 20);
        wait_end();
        w = {q[2 + 4*255], q[3 + 4*255], q[4 + 4*255], q[5 + 4*255]};
        chk("full_nwrites", 64'(wlog.size()), 64'd256);
        if (wlog.size() == 256) chk("full_last", 64'(wlog[255]), {24'd0, 8'hFF, w});
        chk("full_cpurun", 64'(cpu_run), 64'd1);
        pulse_restart();

        // Reset after two data bytes, then a clean one-word load
        wlog.delete();
        q = '{8'h00, 8'h02, 8'hAB, 8'hCD};
        send_q(q, 0);
        do_reset();
        chk("rst_nwrites", 64'(wlog.size()), 64'd0);
        q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        send_q(q, 30);
        wait_end();
        chk("post_nwrites", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("post_w0", 64'(wlog[0]), 64'h00_1234_5678);
        pulse_restart();

        // Random loads, some oversized
        for (int k = 0; k < 6; k++) begin
            n = ($urandom_range(4) == 0) ? int'($urandom_range(300, 257)) : int'($urandom_range(20));
            q = '{8'(n >> 8), 8'(n)};
            if (n <= DEPTH) for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            send_q(q, int'($urandom_range(60)));
            wait_end();
            repeat ($urandom_range(3)) @(posedge clock);
            #0;
            pulse_restart();
        end
        repeat (3) @(posedge clock);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
